// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (IF)
// and data access (DM), with a registered req/gnt/done handshake per port.
module mem_port_arbiter #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic {PORT_IF, PORT_DM} port_t;

   state_t            state, state_nxt;
   port_t             owner, prio_last, winner;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_we;
   logic              any_req, last_cycle, in_access, in_resp;

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
   end

   assign any_req    = if_req | dm_req;
   assign last_cycle = (wait_cnt == 4'(WAIT_CYCLES - 1));
   assign in_access  = (state == ACCESS);
   assign in_resp    = (state == RESP);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      winner = PORT_IF;
      if (if_req && dm_req) begin
         // A tie goes to whichever port was not served last.
         if (prio_last == PORT_IF) winner = PORT_DM;
      end else if (dm_req) begin
         winner = PORT_DM;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  if (last_cycle) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner     <= PORT_IF;
         prio_last <= PORT_DM;
         wait_cnt  <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               owner    <= winner;
               wait_cnt <= '0;
               if (winner == PORT_DM) begin
                  lat_addr  <= dm_addr;
                  lat_wdata <= dm_wdata;
                  lat_we    <= dm_we;
               end else begin
                  lat_addr  <= if_addr;
                  lat_wdata <= '0;
                  lat_we    <= 1'b0;
               end
            end
            ACCESS: begin
               wait_cnt <= wait_cnt + 4'd1;
               if (last_cycle && !lat_we) begin
                  if (owner == PORT_DM) dm_rdata <= mem_rdata;
                  else                  if_rdata <= mem_rdata;
               end
            end
            RESP:    prio_last <= owner;
            default: ;
         endcase
      end
   end

   // Handshake and memory pins decode from registered state, so they are all 0 in reset.
   assign if_gnt    = in_access && (owner == PORT_IF);
   assign dm_gnt    = in_access && (owner == PORT_DM);
   assign if_done   = in_resp && (owner == PORT_IF);
   assign dm_done   = in_resp && (owner == PORT_DM);
   assign mem_addr  = in_access ? lat_addr  : '0;
   assign mem_wdata = in_access ? lat_wdata : '0;
   assign mem_read  = in_access && !lat_we;
   assign mem_write = in_access && lat_we && last_cycle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT_CYCLES 1 and 3) checked every cycle
// against a transaction-timeline reference model, plus directed scenario checks.
module tb_mem_port_arbiter;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic       if_req [N], dm_req [N], dm_we [N];
   logic [7:0] if_addr [N], dm_addr [N], dm_wdata [N];
   logic       if_gnt [N], if_done [N], dm_gnt [N], dm_done [N], mem_write [N], mem_read [N];
   logic [7:0] if_rdata [N], dm_rdata [N], mem_addr [N], mem_wdata [N], mem_rdata [N];
   logic [7:0] mem [N][256];
   logic [7:0] ref_mem [N][256];

   assign mem_rdata[0] = mem[0][mem_addr[0]];
   assign mem_rdata[1] = mem[1][mem_addr[1]];

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
      .if_rdata(if_rdata[0]), .if_done(if_done[0]),
      .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
      .dm_gnt(dm_gnt[0]), .dm_rdata(dm_rdata[0]), .dm_done(dm_done[0]),
      .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_write(mem_write[0]),
      .mem_read(mem_read[0]), .mem_rdata(mem_rdata[0])
   );

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
      .if_rdata(if_rdata[1]), .if_done(if_done[1]),
      .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
      .dm_gnt(dm_gnt[1]), .dm_rdata(dm_rdata[1]), .dm_done(dm_done[1]),
      .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_write(mem_write[1]),
      .mem_read(mem_read[1]), .mem_rdata(mem_rdata[1])
   );

   // Reference model: a transaction is either absent or at cycle k of its timeline
   // (k < WAIT_CYCLES is the memory access, k == WAIT_CYCLES is the response).
   typedef struct {
      bit         busy;
      int         k;
      bit         owner;       // 0 = IF, 1 = DM
      bit         prio_last;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] if_rd;
      logic [7:0] dm_rd;
   } model_t;

   model_t m [N];
   int     n_tests = 0;
   int     n_fail  = 0;
   int     wr_cnt [N], rd_cnt [N], done_cnt [N];
   int     order [N][$];

   function automatic int wc(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset(input int d);
      m[d] = '{default: 0};
      m[d].prio_last = 1'b1;
   endtask

   task automatic model_step(input int d);
      int w = wc(d);
      bit pick_dm;
      if (!rst_n) begin
         model_reset(d);
      end else if (!m[d].busy) begin
         if (if_req[d] || dm_req[d]) begin
            pick_dm     = (if_req[d] && dm_req[d]) ? !m[d].prio_last : dm_req[d];
            m[d].busy   = 1'b1;
            m[d].k      = 0;
            m[d].owner  = pick_dm;
            m[d].addr   = pick_dm ? dm_addr[d] : if_addr[d];
            m[d].we     = pick_dm && dm_we[d];
            m[d].wdata  = pick_dm ? dm_wdata[d] : 8'h00;
         end
      end else if (m[d].k < w) begin
         if (m[d].k == w - 1) begin
            if (m[d].we)         ref_mem[d][m[d].addr] = m[d].wdata;
            else if (m[d].owner) m[d].dm_rd = ref_mem[d][m[d].addr];
            else                 m[d].if_rd = ref_mem[d][m[d].addr];
         end
         m[d].k++;
      end else begin
         m[d].busy      = 1'b0;
         m[d].prio_last = m[d].owner;
      end
   endtask

   function automatic logic [37:0] exp_vec(input int d);
      int w    = wc(d);
      bit acc  = m[d].busy && (m[d].k < w);
      bit resp = m[d].busy && (m[d].k == w);
      return {acc && !m[d].owner, resp && !m[d].owner, m[d].if_rd,
              acc && m[d].owner, resp && m[d].owner, m[d].dm_rd,
              acc ? m[d].addr : 8'h00, acc ? m[d].wdata : 8'h00,
              acc && m[d].we && (m[d].k == w - 1), acc && !m[d].we};
   endfunction

   function automatic logic [37:0] dut_vec(input int d);
      return {if_gnt[d], if_done[d], if_rdata[d], dm_gnt[d], dm_done[d], dm_rdata[d],
              mem_addr[d], mem_wdata[d], mem_write[d], mem_read[d]};
   endfunction

   // One clock: the model consumes the inputs driven this cycle, the bench memory
   // performs any pending write just after the edge, outputs are compared at negedge.
   task automatic tick();
      logic       wr [N];
      logic [7:0] wa [N], wv [N];
      for (int d = 0; d < N; d++) begin
         wr[d] = mem_write[d];
         wa[d] = mem_addr[d];
         wv[d] = mem_wdata[d];
         model_step(d);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < N; d++) if (wr[d]) mem[d][wa[d]] = wv[d];
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
         check($sformatf("d%0d outputs", d), 64'(dut_vec(d)), 64'(exp_vec(d)));
         wr_cnt[d]   += int'(mem_write[d]);
         rd_cnt[d]   += int'(mem_read[d]);
         done_cnt[d] += int'(if_done[d]) + int'(dm_done[d]);
      end
   endtask

   task automatic do_txn(input int d, input bit dm, input bit we, input logic [7:0] a,
                         input logic [7:0] wd, output int lat);
      if (dm) begin
         dm_req[d] = 1'b1; dm_we[d] = we; dm_addr[d] = a; dm_wdata[d] = wd;
      end else begin
         if_req[d] = 1'b1; if_addr[d] = a;
      end
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!(dm ? dm_done[d] : if_done[d]) && lat < 40);
      if_req[d] = 1'b0;
      dm_req[d] = 1'b0;
      tick();
   endtask

   initial begin
      int lat;
      for (int d = 0; d < N; d++) begin
         if_req[d] = 1'b0; dm_req[d] = 1'b0; dm_we[d] = 1'b0;
         if_addr[d] = 8'h00; dm_addr[d] = 8'h00; dm_wdata[d] = 8'h00;
         wr_cnt[d] = 0; rd_cnt[d] = 0; done_cnt[d] = 0;
         for (int a = 0; a < 256; a++) begin
            mem[d][a]     = 8'($urandom);
            ref_mem[d][a] = mem[d][a];
         end
      end

      // Reset state: every output 0
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < N; d++) begin
         model_reset(d);
         check($sformatf("d%0d reset outputs", d), 64'(dut_vec(d)), 64'(0));
      end

      // Both requests held from reset: grants must alternate IF, DM, IF, ...
      for (int d = 0; d < N; d++) begin
         if_req[d] = 1'b1; if_addr[d] = 8'h05;
         dm_req[d] = 1'b1; dm_we[d] = 1'b0; dm_addr[d] = 8'h09;
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 60 && (order[0].size() < 6 || order[1].size() < 6); c++) begin
         tick();
         for (int d = 0; d < N; d++) begin
            if (if_done[d] && order[d].size() < 6) order[d].push_back(0);
            if (dm_done[d] && order[d].size() < 6) order[d].push_back(1);
         end
      end
      for (int d = 0; d < N; d++) begin
         if_req[d] = 1'b0;
         dm_req[d] = 1'b0;
         check($sformatf("d%0d fair count", d), 64'(order[d].size()), 64'(6));
         for (int i = 0; i < order[d].size(); i++)
            check($sformatf("d%0d fair grant %0d", d, i), 64'(order[d][i]), 64'(i % 2));
      end
      repeat (6) tick();

      // Fetch read of a preloaded byte
      for (int d = 0; d < N; d++) begin
         mem[d][100] = 8'hA9;
         ref_mem[d][100] = 8'hA9;
         do_txn(d, 1'b0, 1'b0, 8'd100, 8'h00, lat);
         check($sformatf("d%0d if latency", d), 64'(lat), 64'(wc(d) + 1));
         check($sformatf("d%0d if_rdata", d), 64'(if_rdata[d]), 64'hA9);
      end

      // Data write then read back; exactly one write strobe
      for (int d = 0; d < N; d++) begin
         wr_cnt[d] = 0;
         do_txn(d, 1'b1, 1'b1, 8'h20, 8'h5C, lat);
         do_txn(d, 1'b1, 1'b0, 8'h20, 8'h00, lat);
         check($sformatf("d%0d write strobes", d), 64'(wr_cnt[d]), 64'(1));
         check($sformatf("d%0d mem[20]", d), 64'(mem[d][8'h20]), 64'h5C);
         check($sformatf("d%0d dm_rdata", d), 64'(dm_rdata[d]), 64'h5C);
      end

      // Read strobe held for every access cycle
      for (int d = 0; d < N; d++) begin
         rd_cnt[d] = 0;
         do_txn(d, 1'b0, 1'b0, 8'h40, 8'h00, lat);
         check($sformatf("d%0d read strobes", d), 64'(rd_cnt[d]), 64'(wc(d)));
         check($sformatf("d%0d read latency", d), 64'(lat), 64'(wc(d) + 1));
      end

      // Request dropped one cycle after grant: one done, no follow-on transaction
      for (int d = 0; d < N; d++) begin
         dm_req[d] = 1'b1; dm_we[d] = 1'b0; dm_addr[d] = 8'h11;
         done_cnt[d] = 0;
      end
      tick();
      tick();
      for (int d = 0; d < N; d++) dm_req[d] = 1'b0;
      repeat (8) tick();
      for (int d = 0; d < N; d++)
         check($sformatf("d%0d dropped-req dones", d), 64'(done_cnt[d]), 64'(1));

      // Reset during the access of a write aborts it
      for (int d = 0; d < N; d++) begin
         dm_req[d] = 1'b1; dm_we[d] = 1'b1; dm_addr[d] = 8'h30; dm_wdata[d] = ~ref_mem[d][8'h30];
      end
      tick();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < N; d++) begin
         model_reset(d);
         check($sformatf("d%0d async reset outputs", d), 64'(dut_vec(d)), 64'(0));
         dm_req[d] = 1'b0;
         done_cnt[d] = 0;
      end
      tick();
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      for (int d = 0; d < N; d++) begin
         check($sformatf("d%0d mem[30] kept", d), 64'(mem[d][8'h30]), 64'(ref_mem[d][8'h30]));
         check($sformatf("d%0d aborted dones", d), 64'(done_cnt[d]), 64'(0));
      end

      // Randomized traffic, including mid-access request and input changes
      for (int c = 0; c < 3000; c++) begin
         for (int d = 0; d < N; d++) begin
            if ($urandom_range(0, 3) == 0) begin
               if_req[d]   = ($urandom_range(0, 9) < 6);
               dm_req[d]   = ($urandom_range(0, 9) < 6);
               dm_we[d]    = 1'($urandom);
               if_addr[d]  = 8'($urandom_range(0, 15));
               dm_addr[d]  = 8'($urandom_range(0, 15));
               dm_wdata[d] = 8'($urandom);
            end
         end
         tick();
      end
      for (int d = 0; d < N; d++) begin
         if_req[d] = 1'b0;
         dm_req[d] = 1'b0;
      end
      repeat (8) tick();
      for (int d = 0; d < N; d++)
         for (int a = 0; a < 16; a++)
            check($sformatf("d%0d final mem[%0d]", d, a), 64'(mem[d][a]), 64'(ref_mem[d][a]));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
